// File: rtl/floor_call_encoder.sv
// floor_call_encoder: debounced floor-call buttons turned into round-robin floor requests on a valid/ready handshake
// Ports: clk; rst_n (sync, active-high); BTN[i] raw call for floor i+1; elev_f_o/arrive retire a call;
// req_valid/req_floor/req_ready request handshake; LED pending bitmap. Optional: FLOOR_CALL_CANCEL_EN (second press cancels)
module floor_call_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] BTN,
  input  logic [2:0] elev_f_o,
  input  logic       arrive,
  input  logic       req_ready,
  output logic       req_valid,
  output logic [2:0] req_floor,
  output logic [6:0] LED
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state, state_n;
  logic [6:0] sync1, sync2, stable, stable_q, pending, issued, pending_n, issued_n;
  logic [6:0] press, clr, cancel, avail, iss_set, rot;
  logic [CNT_W-1:0] cnt [7];
  logic [2:0] ptr, ptr_n, sel, off, floor_n;
  logic [3:0] sum;
  logic valid_n;
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      stable_q <= '0;
      for (int i = 0; i < 7; i++) cnt[i] <= '0;
    end else begin
      sync1 <= BTN;
      sync2 <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 7; i++) begin
        if (sync2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          stable[i] <= ~stable[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  assign press = stable & ~stable_q;
  assign clr = (arrive && elev_f_o != 3'd0) ? 7'(1) << (elev_f_o - 3'd1) : '0;
`ifdef FLOOR_CALL_CANCEL_EN
  logic [6:0] offered;
  assign offered = req_valid ? 7'(1) << (req_floor - 3'd1) : '0;
  assign cancel = press & pending & ~issued & ~offered;
`else
  assign cancel = '0;
`endif
  // a floor being retired or cancelled this cycle must not be picked for a new offer
  assign avail = pending & ~issued & ~clr & ~cancel;
  assign pending_n = (pending | press) & ~cancel & ~clr;
  assign issued_n = (issued | iss_set) & ~clr;
  assign LED = pending;
  always_comb begin
    rot = 7'({avail, avail} >> ptr);
    off = '0;
    for (int k = 6; k >= 0; k--) if (rot[k]) off = 3'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    sel = sum >= 4'd7 ? 3'(sum - 4'd6) : 3'(sum + 4'd1);
    state_n = state;
    valid_n = 1'b0;
    floor_n = '0;
    ptr_n = ptr;
    iss_set = '0;
    if (state == IDLE) begin
      if (|avail) begin
        state_n = OFFER;
        valid_n = 1'b1;
        floor_n = sel;
      end
    end else if (arrive && elev_f_o == req_floor) state_n = IDLE;
    else if (req_ready) begin
      state_n = IDLE;
      iss_set = 7'(1) << (req_floor - 3'd1);
      ptr_n = req_floor;
    end else begin
      valid_n = 1'b1;
      floor_n = req_floor;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= IDLE;
      req_valid <= 1'b0;
      req_floor <= '0;
      ptr <= 3'd7;
      pending <= '0;
      issued <= '0;
    end else begin
      state <= state_n;
      req_valid <= valid_n;
      req_floor <= floor_n;
      ptr <= ptr_n;
      pending <= pending_n;
      issued <= issued_n;
    end
  end
endmodule

// File: tb/tb_floor_call_encoder.sv
// tb_floor_call_encoder: scoreboard bench with a call-list reference model for floor_call_encoder
module tb_floor_call_encoder;
  logic clk = 1'b0;
  logic rst_n, arrive, req_ready, req_valid;
  logic [6:0] BTN, LED, mpend;
  logic [2:0] elev_f_o, req_floor;
  int n_checks = 0;
  int n_fail = 0;
  int mptr = 7;
  int exp_q[$];
  floor_call_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .BTN(BTN), .elev_f_o(elev_f_o), .arrive(arrive),
    .req_ready(req_ready), .req_valid(req_valid), .req_floor(req_floor), .LED(LED)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic press(input logic [6:0] m);
    BTN = m;
    repeat (8) tick();
    BTN = '0;
    repeat (8) tick();
  endtask
  task automatic rr(input logic [6:0] m);
    for (int k = 1; k <= 7; k++) begin
      int f;
      f = (mptr - 1 + k) % 7 + 1;
      if (m[f-1]) exp_q.push_back(f);
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!req_valid && n < 60) begin
      tick();
      n++;
    end
    chk("offer_timeout", int'(req_valid), 1);
  endtask
  task automatic accept(input int n);
    repeat (n) begin
      wait_valid();
      repeat ($urandom_range(0, 2)) tick();
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
    end
  endtask
  task automatic retire(input int f);
    elev_f_o = 3'(f);
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    elev_f_o = '0;
    mpend[f-1] = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!req_valid) chk("idle_floor_zero", int'(req_floor), 0);
    else if (req_ready && !(arrive && elev_f_o == req_floor)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_offer: got floor %0d, expected none", req_floor);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("offer_floor", int'(req_floor), e);
        mptr = e;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b1;
    BTN = '0;
    elev_f_o = '0;
    arrive = 1'b0;
    req_ready = 1'b0;
    mpend = '0;
    repeat (3) tick();
    chk("reset_valid", int'(req_valid), 0);
    chk("reset_floor", int'(req_floor), 0);
    chk("reset_led", int'(LED), 0);
    rst_n = 1'b0;
    BTN = 7'h04;
    repeat (6) tick();
    chk("debounce_early_led", int'(LED), 0);
    tick();
    chk("debounce_led", int'(LED), 4);
    chk("debounce_no_valid_yet", int'(req_valid), 0);
    tick();
    chk("first_offer_valid", int'(req_valid), 1);
    chk("first_offer_floor", int'(req_floor), 3);
    arrive = 1'b1;
    elev_f_o = 3'd3;
    req_ready = 1'b1;
    tick();
    arrive = 1'b0;
    elev_f_o = '0;
    req_ready = 1'b0;
    chk("withdraw_valid", int'(req_valid), 0);
    chk("withdraw_led", int'(LED), 0);
    BTN = '0;
    repeat (10) tick();
    chk("withdraw_no_reoffer", int'(req_valid), 0);
    BTN = 7'h10;
    repeat (3) tick();
    BTN = '0;
    repeat (12) tick();
    chk("glitch_led", int'(LED), 0);
    chk("glitch_valid", int'(req_valid), 0);
    press(7'b0110010);
    mpend |= 7'b0110010;
    chk("rr_led", int'(LED), int'(mpend));
    rr(7'b0110010);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("hold_floor", int'(req_floor), 2);
      tick();
    end
    accept(3);
    press(7'b0000101);
    mpend |= 7'b0000101;
    rr(7'b0000101);
    accept(2);
    chk("after_wrap_led", int'(LED), int'(mpend));
    retire(5);
    chk("retire_led", int'(LED), int'(mpend));
    press(7'b0010000);
    mpend |= 7'b0010000;
    rr(7'b0010000);
    accept(1);
    for (int f = 1; f <= 7; f++) retire(f);
    chk("retire_all_led", int'(LED), 0);
    press(7'h60);
    mpend |= 7'h60;
    wait_valid();
    chk("cancel_first_offer", int'(req_floor), 6);
    press(7'h40);
`ifdef FLOOR_CALL_CANCEL_EN
    mpend[6] = 1'b0;
    rr(7'h20);
`else
    rr(7'h60);
`endif
    chk("cancel_led", int'(LED), int'(mpend));
    accept(1);
`ifdef FLOOR_CALL_CANCEL_EN
    repeat (10) tick();
    chk("cancel_no_offer", int'(req_valid), 0);
`else
    accept(1);
`endif
    for (int f = 1; f <= 7; f++) retire(f);
    for (int r = 0; r < 12; r++) begin
      logic [6:0] m;
      int s;
      m = 7'($urandom_range(1, 127));
      press(m);
      mpend |= m;
      chk("rand_press_led", int'(LED), int'(mpend));
      rr(m);
      accept($countones(m));
      s = $urandom_range(0, 6);
      for (int j = 0; j < 7; j++) begin
        int f;
        f = (s + j) % 7 + 1;
        if (m[f-1]) begin
          if ($urandom_range(0, 1) == 1) begin
            elev_f_o = 3'd0;
            arrive = 1'b1;
            tick();
            arrive = 1'b0;
            chk("rand_zero_arrive_led", int'(LED), int'(mpend));
          end
          retire(f);
          chk("rand_retire_led", int'(LED), int'(mpend));
        end
      end
      tick();
      chk("rand_idle_valid", int'(req_valid), 0);
    end
    press(7'h08);
    wait_valid();
    rst_n = 1'b1;
    tick();
    chk("reset_mid_offer_valid", int'(req_valid), 0);
    chk("reset_mid_offer_floor", int'(req_floor), 0);
    chk("reset_mid_offer_led", int'(LED), 0);
    rst_n = 1'b0;
    repeat (10) tick();
    chk("reset_no_retained_offer", int'(req_valid), 0);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
